// File: rtl/divider_scheduler.sv
// Round-robin scheduler that time-shares one sequential divider among NUM_VOICES voices.
// Optional feature macro DIV_SCHED_OVERRUN_EN adds a sticky per-voice overrun output.
module divider_scheduler #(
  parameter int NUM_VOICES  = 4,
  parameter int DATA_W      = 16,
  parameter int DIV_LATENCY = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_VOICES-1:0]        req,
  input  logic [NUM_VOICES*DATA_W-1:0] osc_in,
  input  logic [NUM_VOICES*DATA_W-1:0] divisor_in,
  output logic                         div_start,
  output logic [DATA_W-1:0]            div_dividend,
  output logic [DATA_W-1:0]            div_divisor,
  input  logic [7:0]                   div_q,
  output logic [NUM_VOICES*8-1:0]      q_out,
  output logic [NUM_VOICES-1:0]        q_valid,
`ifdef DIV_SCHED_OVERRUN_EN
  output logic [NUM_VOICES-1:0]        overrun,
`endif
  output logic                         busy
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);
  localparam logic [PTR_W:0] NV = (PTR_W+1)'(NUM_VOICES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_VOICES-1:0]   pending_q, pending_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    div_zero_q, div_zero_d;
  logic                    div_start_q, div_start_d;
  logic [DATA_W-1:0]       dividend_q, dividend_d;
  logic [DATA_W-1:0]       divisor_q, divisor_d;
  logic [NUM_VOICES-1:0]   q_valid_q, q_valid_d;
  logic [7:0]              q_out_q [NUM_VOICES];
  logic [7:0]              q_out_d [NUM_VOICES];
  logic [DATA_W-1:0]       osc_slot_q [NUM_VOICES];
  logic [DATA_W-1:0]       osc_slot_d [NUM_VOICES];
  logic [DATA_W-1:0]       dvs_slot_q [NUM_VOICES];
  logic [DATA_W-1:0]       dvs_slot_d [NUM_VOICES];

  logic [PTR_W-1:0]        pick;
  logic                    found;

  // First pending voice at or after rr_ptr, wrapping at NUM_VOICES.
  always_comb begin
    logic [PTR_W:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (idx >= NV) idx = idx - NV;
      if (!found && pending_q[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    div_zero_d  = div_zero_q;
    div_start_d = 1'b0;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    q_valid_d   = '0;
    q_out_d     = q_out_q;
    osc_slot_d  = osc_slot_q;
    dvs_slot_d  = dvs_slot_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d          = pick;
          dividend_d       = osc_slot_q[pick];
          divisor_d        = dvs_slot_q[pick];
          pending_d[pick]  = 1'b0;
          if (dvs_slot_q[pick] == '0) begin
            div_zero_d = 1'b1;
            state_d    = S_CAPTURE;
          end else begin
            div_zero_d  = 1'b0;
            div_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(DIV_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CAPTURE: begin
        q_out_d[grant_q]   = div_zero_q ? 8'h00 : div_q;
        q_valid_d[grant_q] = 1'b1;
        rr_ptr_d           = (grant_q == PTR_W'(NUM_VOICES - 1)) ? '0 : grant_q + PTR_W'(1);
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Applied after the grant clear so a same-cycle request re-arms the voice.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (req[v]) begin
        pending_d[v]  = 1'b1;
        osc_slot_d[v] = osc_in[v*DATA_W +: DATA_W];
        dvs_slot_d[v] = divisor_in[v*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      div_zero_q  <= 1'b0;
      div_start_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      q_valid_q   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        q_out_q[v]    <= '0;
        osc_slot_q[v] <= '0;
        dvs_slot_q[v] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      div_zero_q  <= div_zero_d;
      div_start_q <= div_start_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      q_valid_q   <= q_valid_d;
      q_out_q     <= q_out_d;
      osc_slot_q  <= osc_slot_d;
      dvs_slot_q  <= dvs_slot_d;
    end
  end

`ifdef DIV_SCHED_OVERRUN_EN
  logic [NUM_VOICES-1:0] overrun_q, overrun_d;
  logic [NUM_VOICES-1:0] inflight;

  always_comb begin
    inflight  = busy ? (NUM_VOICES'(1) << grant_q) : '0;
    overrun_d = overrun_q | (req & (pending_q | inflight));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= '0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_qout
      assign q_out[gi*8 +: 8] = q_out_q[gi];
    end
  endgenerate

  assign div_start    = div_start_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign q_valid      = q_valid_q;
  assign busy         = (state_q != S_IDLE);

endmodule
